mem_port_arbiter: RTL and testbench

Shares one memory-controller port (the SRAM/cache controller interface) between the IF stage (instruction fetch) and the MEM stage (data load/store). Data accesses have priority. A starvation counter guarantees instruction fetches progress. Per-requester ready outputs follow the existing freeze convention: freeze = ~ready.

---
 rtl/arb_pkg.sv | 12 +
 rtl/arb_starve_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the IF/MEM memory-port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_D = 2'b01,
        GRANT_I = 2'b10
    } arb_state_e;

    localparam int ARB_STARVE_LIMIT = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of data grants taken while a fetch waits.
module arb_starve_counter #(
    parameter int CNT_W = 3,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    assign at_limit = (cnt == LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one controller port between fetch and data; data wins unless
// the fetch has been starved for STARVE_LIMIT consecutive data grants.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_rd_en,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              grant_i,
    output logic              grant_d
);

    arb_state_e state;
    arb_state_e state_nxt;

    logic d_req;
    logic grant_start;
    logic at_limit;
    logic cnt_inc;
    logic cnt_clr;

    assign d_req = d_rd_en | d_wr_en;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req && at_limit) begin
                    state_nxt = GRANT_I;
                end else if (d_req) begin
                    state_nxt = GRANT_D;
                end else if (i_req) begin
                    state_nxt = GRANT_I;
                end
            end
            GRANT_D, GRANT_I: begin
                if (m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_start = (state == IDLE) && (state_nxt != IDLE);
    assign cnt_inc     = grant_start && (state_nxt == GRANT_D) && i_req;
    assign cnt_clr     = (state == IDLE) && (!i_req || state_nxt == GRANT_I);

    arb_starve_counter #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .at_limit (at_limit)
    );

    // Controller-side signals are latched once per grant and held to completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant_start) begin
                m_req <= 1'b1;
                if (state_nxt == GRANT_D) begin
                    m_we    <= d_wr_en;
                    m_addr  <= d_addr;
                    m_wdata <= d_wdata;
                end else begin
                    m_we    <= 1'b0;
                    m_addr  <= i_addr;
                    m_wdata <= '0;
                end
            end else if (state != IDLE && m_ready) begin
                m_req <= 1'b0;
            end
        end
    end

    assign grant_d = (state == GRANT_D);
    assign grant_i = (state == GRANT_I);

    assign d_ready = ~d_req | (grant_d & m_ready);
    assign i_ready = ~i_req | (grant_i & m_ready);

    assign d_rdata = m_rdata;
    assign i_rdata = m_rdata;

    ready_in_idle: assert property (
        @(posedge clk) disable iff (rst) (state == IDLE) |-> !m_ready
    );

    data_held_in_grant: assert property (
        @(posedge clk) disable iff (rst) (state == GRANT_D) |-> d_req
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a cycle model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_rd_en = 1'b0;
    logic          d_wr_en = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ready = 1'b0;
    logic          grant_i;
    logic          grant_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIM),
        .CNT_W        (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .d_rd_en (d_rd_en),
        .d_wr_en (d_wr_en),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller model: answers each m_req after ctl_delay wait cycles.
    int            ctl_delay  = 0;
    int            ctl_left   = 0;
    bit            ctl_active = 1'b0;
    bit            ctl_fixed  = 1'b0;
    logic [DW-1:0] ctl_data   = '0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_req && !rst) begin
            if (!ctl_active) begin
                ctl_active = 1'b1;
                ctl_left   = ctl_delay;
            end
            if (ctl_left == 0) begin
                m_ready    = 1'b1;
                m_rdata    = ctl_fixed ? ctl_data : DW'($urandom);
                ctl_active = 1'b0;
            end else begin
                m_ready  = 1'b0;
                m_rdata  = DW'($urandom);
                ctl_left = ctl_left - 1;
            end
        end else begin
            m_ready    = 1'b0;
            ctl_active = 1'b0;
            m_rdata    = DW'($urandom);
        end
    endtask

    // Reference: owner 0=none 1=data 2=fetch, plus data-grants-while-fetch-waits.
    int            mo_owner = 0;
    int            mo_wait  = 0;
    logic [AW-1:0] mo_addr  = '0;
    logic [DW-1:0] mo_wdata = '0;
    logic          mo_we    = 1'b0;

    always @(negedge clk) begin : model
        logic dq;
        logic exp_dr;
        logic exp_ir;
        if (rst) begin
            mo_owner = 0;
            mo_wait  = 0;
            mo_addr  = '0;
            mo_wdata = '0;
            mo_we    = 1'b0;
        end
        dq     = d_rd_en | d_wr_en;
        exp_dr = !dq || (mo_owner == 1 && m_ready);
        exp_ir = !i_req || (mo_owner == 2 && m_ready);
        check("grant_d", grant_d, mo_owner == 1);
        check("grant_i", grant_i, mo_owner == 2);
        check("m_req", m_req, mo_owner != 0);
        if (mo_owner != 0 || rst) begin
            check("m_addr", m_addr, mo_addr);
            check("m_we", m_we, mo_we);
        end
        if ((mo_owner != 0 && mo_we) || rst) begin
            check("m_wdata", m_wdata, mo_wdata);
        end
        check("d_ready", d_ready, exp_dr);
        check("i_ready", i_ready, exp_ir);
        check("d_rdata", d_rdata, m_rdata);
        check("i_rdata", i_rdata, m_rdata);
        if (!rst) begin
            if (mo_owner != 0) begin
                if (m_ready) mo_owner = 0;
            end else begin
                if (i_req && (mo_wait >= LIM || !dq)) begin
                    mo_owner = 2;
                    mo_addr  = i_addr;
                    mo_we    = 1'b0;
                    mo_wait  = 0;
                end else if (dq) begin
                    mo_owner = 1;
                    mo_addr  = d_addr;
                    mo_we    = d_wr_en;
                    mo_wdata = d_wdata;
                    if (i_req && mo_wait < LIM) mo_wait = mo_wait + 1;
                end
                if (!i_req) mo_wait = 0;
            end
        end
    end

    initial begin : stim
        logic dr_s;
        logic ir_s;
        int   k;
        int   nd;
        int   ni;
        int   d_before [2];

        tick();
        tick();
        rst = 1'b0;

        // Reset in the middle of a data write grant.
        tick();
        d_wr_en = 1'b1; d_addr = 32'h40; d_wdata = 32'h55; ctl_delay = 5;
        tick();
        @(negedge clk);
        check("t1_grant", grant_d, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        check("t1_async_mreq", m_req, 1'b0);
        check("t1_async_grant", grant_d, 1'b0);
        m_ready = 1'b0; ctl_active = 1'b0; d_wr_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t1_rel", {grant_d, grant_i, m_req, m_we}, 4'b0000);
        check("t1_addr", m_addr, 32'h0);
        check("t1_wdata", m_wdata, 32'h0);

        // Lone read, controller answers in the first grant cycle.
        tick();
        d_rd_en = 1'b1; d_addr = 32'h100; ctl_delay = 0;
        ctl_fixed = 1'b1; ctl_data = 32'hDEADBEEF;
        @(negedge clk);
        check("t2_wait", {d_ready, m_req}, 2'b00);
        tick();
        @(negedge clk);
        check("t2_grant", {m_req, m_we, d_ready}, 3'b101);
        check("t2_addr", m_addr, 32'h100);
        check("t2_rdata", d_rdata, 32'hDEADBEEF);
        tick();
        d_rd_en = 1'b0;
        @(negedge clk);
        check("t2_done", m_req, 1'b0);

        // Simultaneous fetch and write: data first, one idle, then fetch.
        tick();
        i_req = 1'b1; i_addr = 32'h8;
        d_wr_en = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234;
        tick();
        @(negedge clk);
        check("t3_d", {grant_d, m_we, d_ready, i_ready}, 4'b1110);
        check("t3_wdata", m_wdata, 32'h1234);
        tick();
        d_wr_en = 1'b0;
        @(negedge clk);
        check("t3_idle", {m_req, i_ready}, 2'b00);
        tick();
        @(negedge clk);
        check("t3_i", {grant_i, m_we, i_ready}, 3'b101);
        check("t3_iaddr", m_addr, 32'h8);
        tick();
        i_req = 1'b0;

        // Starvation: fetch and reads held continuously.
        tick();
        i_req = 1'b1; i_addr = 32'h44; d_rd_en = 1'b1; d_addr = 32'h500;
        nd = 0; ni = 0; d_before[0] = 99; d_before[1] = 99;
        for (int c = 0; c < 40 && ni < 2; c++) begin
            @(negedge clk);
            if (grant_d) nd++;
            if (grant_i) begin
                d_before[ni] = nd;
                nd = 0;
                ni++;
            end
            tick();
        end
        check("t4_fetches", ni, 2);
        check("t4_first", d_before[0], 4);
        check("t4_second", d_before[1], 4);
        i_req = 1'b0; d_rd_en = 1'b0;
        tick();

        // Fetch flushed during a slow grant.
        i_req = 1'b1; i_addr = 32'h60; ctl_delay = 3;
        tick();
        i_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5_hold", {m_req, grant_i, i_ready}, 3'b111);
            check("t5_addr", m_addr, 32'h60);
            check("t5_mready", m_ready, c == 3);
            tick();
        end
        i_req = 1'b1; i_addr = 32'h80; ctl_delay = 0;
        @(negedge clk);
        check("t5_idle", {m_req, i_ready}, 2'b00);
        tick();
        @(negedge clk);
        check("t5_next", {grant_i, i_ready}, 2'b11);
        check("t5_naddr", m_addr, 32'h80);
        tick();
        i_req = 1'b0;

        // Slow write: port signals stable until completion.
        tick();
        d_wr_en = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFE; ctl_delay = 5;
        tick();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t6_port", {m_req, m_we, d_ready}, {2'b11, c == 5});
            check("t6_addr", m_addr, 32'h300);
            check("t6_wdata", m_wdata, 32'hCAFE);
            tick();
        end
        d_wr_en = 1'b0;
        ctl_fixed = 1'b0;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            dr_s = d_ready;
            ir_s = i_ready;
            tick();
            ctl_delay = (c % 500 < 250) ? $urandom_range(0, 1) : $urandom_range(0, 4);
            if ((d_rd_en | d_wr_en) && dr_s) begin
                d_rd_en = 1'b0;
                d_wr_en = 1'b0;
            end
            if (!(d_rd_en | d_wr_en) && $urandom_range(0, 9) < (c < 1500 ? 3 : 8)) begin
                k       = $urandom_range(0, 7);
                d_rd_en = (k < 4) || (k == 7);
                d_wr_en = (k >= 4);
                d_addr  = $urandom & 32'hFFFF_FFFC;
                d_wdata = $urandom;
            end
            if (i_req && (ir_s || $urandom_range(0, 15) == 0)) begin
                i_req = 1'b0;
            end else if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req  = 1'b1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
        end

        // Let any open access finish before stopping.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            dr_s = d_ready;
            ir_s = i_ready;
            tick();
            if (dr_s) begin
                d_rd_en = 1'b0;
                d_wr_en = 1'b0;
            end
            if (ir_s) i_req = 1'b0;
        end
        @(negedge clk);
        check("end_idle", m_req, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
